// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-byte stream bundle between uart_rx_fifo and its consumer
//
// Purpose: groups the show-ahead FIFO read side into one port.
// Signals:
//   rx_data  [7:0]  head byte of the receive FIFO (0 while empty)
//   rx_valid        FIFO non-empty
//   rx_ready        consumer pop request; a byte leaves on rx_valid & rx_ready
// Modports:
//   master  the receiver (drives rx_data/rx_valid, reads rx_ready)
//   slave   the consumer (reads rx_data/rx_valid, drives rx_ready)

interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling 8N1 UART receiver with show-ahead receive FIFO
//
// Purpose: recovers UART frames from rx using a clocks-per-bit divisor and
// queues good bytes in a FIFO read through a valid/ready stream.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames, adds parity_err).
// Parameters:
//   FIFO_DEPTH  FIFO entries, power of two, 2..256
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   rx          serial line, idle high
//   baud_div    clocks per bit, latched at start-bit detection, clamped to >= 4
//   stream      master side of uart_rx_fifo_if (rx_data, rx_valid, rx_ready)
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good byte dropped because the FIFO was full
//   parity_err  one-cycle pulse: parity mismatch on a good-stop frame (parity build only)
//   fifo_count  current FIFO occupancy

module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic [15:0]                   baud_div,
  uart_rx_fifo_if.master                stream,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;
`endif

  // ---------------------------------------------------------------------
  // Input synchronizer; both flops reset to the idle level so a reset
  // never looks like a start bit.
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------
  state_t      state;
  state_t      state_n;
  logic [15:0] bd;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  logic        timer_clr;
  logic        bd_load;
  logic        shift_en;
  logic        push;
  logic        ferr_set;

  logic [15:0] bd_in;
  logic [15:0] bd_last;
  logic [15:0] half_last;

`ifdef UART_RX_PARITY_EN
  logic        par_bit;
  logic        par_load;
  logic        perr_set;
`endif

  assign bd_in     = (baud_div < 16'd4) ? 16'd4 : baud_div;
  assign bd_last   = bd - 16'd1;
  // Start bit is re-checked half a bit in, which centres every later sample.
  assign half_last = {1'b0, bd[15:1]} - 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_clr = 1'b0;
    bd_load   = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_load  = 1'b0;
    perr_set  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_n   = S_START;
          timer_clr = 1'b1;
          bd_load   = 1'b1;
        end
      end
      S_START: begin
        if (timer == half_last) begin
          if (!rxs) begin
            state_n   = S_DATA;
            timer_clr = 1'b1;
          end else begin
            state_n   = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer == bd_last) begin
          shift_en  = 1'b1;
          timer_clr = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (timer == bd_last) begin
          par_load  = 1'b1;
          timer_clr = 1'b1;
          state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (timer == bd_last) begin
          if (rxs) begin
            // Re-arm immediately so the next start edge, which may come
            // half a bit later, is not missed.
            push    = 1'b1;
            state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
            perr_set = ^{shift, par_bit};
`endif
          end else begin
            ferr_set = 1'b1;
            state_n  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line stays here so it reports only one frame error.
        if (rxs) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd      <= 16'd4;
      timer   <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (bd_load) begin
        bd <= bd_in;
      end
      if (timer_clr || state == S_IDLE || state == S_BREAK) begin
        timer <= 16'd0;
      end else begin
        timer <= timer + 16'd1;
      end
      if (state == S_START) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shift <= {rxs, shift[7:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_load) begin
        par_bit <= rxs;
      end
      parity_err <= perr_set;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Show-ahead receive FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  // A pop request against an empty FIFO is ignored even if a push lands
  // on the same cycle; the pushed byte only becomes visible next cycle.
  assign pop   = !empty && stream.rx_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      frame_err <= ferr_set;
      overrun   <= drop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift;
    end
  end

  // Storage is not reset, so the head is masked to 0 while empty.
  assign stream.rx_data  = empty ? 8'h00 : mem[rd_ptr];
  assign stream.rx_valid = !empty;
  assign fifo_count      = count;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receiver: the reading end of the serial line driven by the team's UART transmitter. It oversamples the incoming line with the same 16-bit clocks-per-bit divisor the transmitter uses, recovers 8N1 frames, and queues received bytes in a show-ahead FIFO behind a valid/ready interface. It flags framing errors and overruns, so the consumer does not have to poll per byte.

## Interface
- FIFO_DEPTH, 8: entries in the receive FIFO; power of two, 2..256.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx  in  1  serial line, idle high.
- baud_div  in  16  clocks per bit; values below 4 are treated as 4.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pop; a byte pops on any cycle with rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte dropped because FIFO full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value rxs.
- baud_div is latched into bd (clamped to ≥4) on start-bit detection. Changes mid-frame have no effect until the next frame.
- Bit timer counts 0..bd-1. Bit index counts 0..7.
- FSM states and transitions:
  - IDLE: rxs=0 -> START, timer cleared.
  - START: at timer = floor(bd/2)-1, sample rxs. If 0 -> DATA, timer cleared. If 1 -> IDLE (glitch rejected, no flag).
  - DATA: at timer = bd-1, sample rxs into shift register, LSB first. After bit 7 -> STOP (or PARITY, see Configuration).
  - STOP: at timer = bd-1, sample rxs.
    - If 1: push the byte, -> IDLE.
    - If 0: frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait for rxs=1, then -> IDLE. A held-low line produces exactly one frame_err.
- FIFO, show-ahead: rx_data always reflects the head entry. The FIFO is only written by the FSM push.
  - Push while full with no pop on the same cycle: byte dropped, overrun pulse, FIFO contents unchanged.
  - Simultaneous push and pop when full: both succeed, count unchanged, no overrun.
  - Simultaneous push and pop when empty: the pop is ignored (rx_valid=0), the push succeeds.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count saturates neither way because it is bounded by the rules above.
- Reset mid-frame: the frame is aborted, the FIFO is emptied, and no flags are raised.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, fifo_count=0. FSM is in IDLE.
- Start detection occurs 2 cycles after the falling edge on rx (synchronizer delay).
- The stop bit is sampled at floor(bd/2) + 9*bd cycles after start detection.
- The push happens on that cycle. rx_valid, rx_data and fifo_count update on the next cycle (1-cycle latency).
- frame_err and overrun assert on the cycle after the stop sample, for exactly one cycle.
- Pop: fifo_count and the head update on the cycle after the rx_valid & rx_ready edge.
- Back-to-back frames: the receiver re-arms in IDLE immediately after the stop sample. Mid-stop-bit arming tolerates up to ±bd/2 of cumulative drift.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is 8E1. After bit 7 the FSM enters PARITY and samples at timer = bd-1.
  - Even parity is checked over data plus the parity bit.
  - Adds output parity_err (1 bit, reset 0). It pulses one cycle after the stop sample when parity mismatches and the stop bit is good.
  - A byte with a parity error is still pushed, so the consumer decides what to do with it.
  - Stop sample occurs at floor(bd/2) + 10*bd.
- UART_RX_PARITY_EN undefined: 8N1 only. No PARITY state and no parity_err port.

## Test plan
- baud_div=8, reset pulse, then transmitter sends 0xAA, 0xF0, 0x0F, 0xCC, 0xEE with rx_ready=1 -> five rx_valid handshakes carrying those bytes in order; frame_err=0 and overrun=0 throughout.
- rx_ready=0, send FIFO_DEPTH+1 frames 0x00..0x08 -> fifo_count reaches 8 and one overrun pulse occurs. Then drain: 0x00..0x07 are read and 0x08 is absent.
- Drive rx low for 3 cycles only, baud_div=8 -> no push and no frame_err; the FSM returns to IDLE and the next frame 0x55 is received correctly.
- Drive a frame 0x3C with the stop bit low, then hold rx low for 40 cycles -> exactly one frame_err and no push; the next valid frame 0xA5 is received.
- Assert reset during bit 4 of a frame while the FIFO holds 2 bytes -> all outputs return to 0 and fifo_count=0; the following frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with a wrong parity bit -> parity_err pulse and 0x07 is pushed. Send 0x07 with correct parity -> no pulse.
